// File: rtl/bit_reverser_pipe_if.sv
// Valid/ready stream bundle for bit_reverser_pipe: request side (in_*) and response side (out_*).
// The master modport belongs to the upstream/downstream environment; the slave modport belongs to the block.
interface bit_reverser_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_mode, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/bit_reverser_pipe.sv
// Pipelined bit/byte permutation unit on a valid/ready stream with a pass-through tag.
// Byte lanes compute the permutation combinationally; STAGES registers carry it with a bubble-free ready chain.

// One byte lane: picks its own byte or the mirrored byte, optionally bit-reversed.
module bit_reverser_lane (
  input  logic [1:0] mode,
  input  logic [7:0] self_b,
  input  logic [7:0] mirr_b,
  output logic [7:0] out_b
);
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[7-j];
    return r;
  endfunction

  always_comb begin
    out_b = self_b;
    unique case (mode)
      2'b00:   out_b = self_b;
      2'b01:   out_b = rev8(mirr_b);
      2'b10:   out_b = mirr_b;
      default: out_b = rev8(self_b);
    endcase
  end
endmodule

module bit_reverser_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  bit_reverser_pipe_if.slave  bus,
  output logic                busy
);
  localparam int LANES = WIDTH / 8;

  if (WIDTH < 8 || (WIDTH % 8) != 0) begin : g_bad_width
    $error("bit_reverser_pipe: WIDTH must be a multiple of 8 and >= 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("bit_reverser_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("bit_reverser_pipe: TAG_W must be >= 1");
  end

  logic [LANES-1:0][7:0] din, xf;
  assign din = bus.in_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bit_reverser_lane u_lane (
      .mode   (bus.in_mode),
      .self_b (din[k]),
      .mirr_b (din[LANES-1-k]),
      .out_b  (xf[k])
    );
  end

  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][WIDTH-1:0]  data_q;
  logic [STAGES:1][TAG_W-1:0]  tag_q;
  logic [STAGES:1]             adv;
  logic [STAGES:1]             up_vld;
  logic [STAGES:1][WIDTH-1:0]  up_data;
  logic [STAGES:1][TAG_W-1:0]  up_tag;

  // A stage may move when any stage at or beyond it is empty, or the sink takes the head beat.
  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    assign adv[k] = bus.out_ready | ~(&vld_pipe[STAGES:k]);
    if (k == 1) begin : g_head
      assign up_vld[k]  = bus.in_valid;
      assign up_data[k] = xf;
      assign up_tag[k]  = bus.in_tag;
    end else begin : g_body
      assign up_vld[k]  = vld_pipe[k-1];
      assign up_data[k] = data_q[k-1];
      assign up_tag[k]  = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= up_vld[k];
          // Payload only loads with a real beat, so an emptied stage keeps its last value.
          if (up_vld[k]) begin
            data_q[k] <= up_data[k];
            tag_q[k]  <= up_tag[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = adv[1];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = data_q[STAGES];
  assign bus.out_tag   = tag_q[STAGES];
  assign busy          = |vld_pipe;
endmodule

// File: tb/tb_bit_reverser_pipe.sv
// Scoreboard bench for bit_reverser_pipe: main instance with STAGES=2, plus STAGES=1 and STAGES=4 instances
// for the latency checks. Expected beats are queued on accept and popped by a separate output monitor.
module tb_bit_reverser_pipe;
  localparam int W  = 64;
  localparam int TW = 4;
  localparam int ND = 3;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        drv_valid = 1'b0;
  logic [1:0]  drv_mode  = 2'b00;
  logic [63:0] drv_data  = '0;
  logic [3:0]  drv_tag   = '0;
  logic [63:0] cur_exp   = '0;
  bit          cur_lat   = 1'b0;
  logic        lat_en    = 1'b0;
  logic        main_ready = 1'b1;
  logic        busy0, busy1, busy4;

  bit_reverser_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus0 ();
  bit_reverser_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus1 ();
  bit_reverser_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus4 ();

  assign bus0.in_valid = drv_valid;
  assign bus0.in_mode  = drv_mode;
  assign bus0.in_data  = drv_data;
  assign bus0.in_tag   = drv_tag;
  assign bus0.out_ready = main_ready;
  assign bus1.in_valid = drv_valid & lat_en;
  assign bus1.in_mode  = drv_mode;
  assign bus1.in_data  = drv_data;
  assign bus1.in_tag   = drv_tag;
  assign bus1.out_ready = 1'b1;
  assign bus4.in_valid = drv_valid & lat_en;
  assign bus4.in_mode  = drv_mode;
  assign bus4.in_data  = drv_data;
  assign bus4.in_tag   = drv_tag;
  assign bus4.out_ready = 1'b1;

  bit_reverser_pipe #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) dut2 (.clk(clk), .rst(rst), .bus(bus0), .busy(busy0));
  bit_reverser_pipe #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .busy(busy1));
  bit_reverser_pipe #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4));

  logic [ND-1:0] i_vld, i_rdy, o_vld, o_rdy, bsy;
  logic [63:0]   o_data [ND];
  logic [3:0]    o_tag  [ND];
  assign i_vld = {bus4.in_valid, bus1.in_valid, bus0.in_valid};
  assign i_rdy = {bus4.in_ready, bus1.in_ready, bus0.in_ready};
  assign o_vld = {bus4.out_valid, bus1.out_valid, bus0.out_valid};
  assign o_rdy = {bus4.out_ready, bus1.out_ready, bus0.out_ready};
  assign bsy   = {busy4, busy1, busy0};
  assign o_data[0] = bus0.out_data;
  assign o_data[1] = bus1.out_data;
  assign o_data[2] = bus4.out_data;
  assign o_tag[0]  = bus0.out_tag;
  assign o_tag[1]  = bus1.out_tag;
  assign o_tag[2]  = bus4.out_tag;

  exp_t        sb [ND][$];
  bit          held [ND];
  logic [63:0] hd [ND];
  logic [3:0]  ht [ND];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Input side pushes expectations, output side pops and compares.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int d = 0; d < ND; d++) held[d] = 1'b0;
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (i_vld[d] && i_rdy[d]) begin
          e.data = cur_exp; e.tag = drv_tag; e.cyc = cyc; e.lat = cur_lat;
          sb[d].push_back(e);
        end
        if (o_vld[d] && !o_rdy[d]) begin
          if (held[d]) begin
            chk($sformatf("hold_data_d%0d", d), o_data[d], hd[d]);
            chk($sformatf("hold_tag_d%0d", d), 64'(o_tag[d]), 64'(ht[d]));
          end
          held[d] = 1'b1; hd[d] = o_data[d]; ht[d] = o_tag[d];
        end else begin
          held[d] = 1'b0;
        end
        if (o_vld[d] && o_rdy[d]) begin
          if (sb[d].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_beat_d%0d: got data %h tag %0d, expected no beat", d, o_data[d], o_tag[d]);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("data_d%0d", d), o_data[d], e.data);
            chk($sformatf("tag_d%0d", d), 64'(o_tag[d]), 64'(e.tag));
            if (e.lat) chk($sformatf("latency_d%0d", d), 64'(cyc - e.cyc), 64'(lat_of(d)));
          end
        end
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [63:0] dat, input logic [3:0] tg,
                      input logic [63:0] ex, input bit lat, input bit rdy_chk);
    int n = 0;
    drv_valid = 1'b1; drv_mode = m; drv_data = dat; drv_tag = tg; cur_exp = ex; cur_lat = lat;
    @(negedge clk);
    if (rdy_chk) chk("in_ready_b2b", 64'(i_rdy[0]), 64'd1);
    while (!i_rdy[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
    @(posedge clk); #1;
  endtask

  logic [1:0]  b2b_mode [8];
  logic [63:0] b2b_in   [8];
  logic [63:0] b2b_out  [8];

  initial begin
    b2b_mode = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    b2b_in   = '{64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_00FF, 64'h1122_3344_5566_7788,
                 64'h0102_0408_1020_4080, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                 64'h0000_0000_0000_00A5, 64'h0123_4567_89AB_CDEF};
    b2b_out  = '{64'hDEAD_BEEF_CAFE_F00D, 64'hFF00_0000_0000_0000, 64'h8877_6655_4433_2211,
                 64'h8040_2010_0804_0201, 64'h0123_4567_89AB_CDEF, 64'hF7B3_D591_E6A2_C480,
                 64'hA500_0000_0000_0000, 64'h80C4_A2E6_91D5_B3F7};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(o_vld[0]), 64'd0);
    chk("rst_out_data", o_data[0], 64'd0);
    chk("rst_out_tag", 64'(o_tag[0]), 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(i_rdy[0]), 64'd1);
    @(posedge clk); #1;

    // Single-beat vectors, one mode each
    send(2'd1, 64'h0000_0000_0000_0001, 4'd3, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    drain();
    send(2'd2, 64'h0123_4567_89AB_CDEF, 4'd4, 64'hEFCD_AB89_6745_2301, 1'b1, 1'b0);
    send(2'd0, 64'h0123_4567_89AB_CDEF, 4'd5, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    send(2'd3, 64'h0000_0000_0000_01F0, 4'd6, 64'h0000_0000_0000_800F, 1'b1, 1'b0);
    send(2'd1, 64'hFFFF_FFFF_0000_0000, 4'd7, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0);
    drain();

    // Back-to-back stream, all modes
    for (int i = 0; i < 8; i++) send(b2b_mode[i], b2b_in[i], 4'(i), b2b_out[i], 1'b1, 1'b1);
    drain();

    // Backpressure: sink stalls for the first five cycles of a ten-beat stream
    fork
      begin
        for (int i = 0; i < 10; i++) send(2'd2, 64'(i), 4'(i), {8'(i), 56'h0}, 1'b0, 1'b0);
      end
      begin
        main_ready = 1'b0;
        repeat (2) @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(i_rdy[0]), 64'd0);
          chk("stall_busy", 64'(bsy[0]), 64'd1);
        end
        @(posedge clk); #1;
        main_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    send(2'd0, 64'hAAAA_AAAA_AAAA_AAAA, 4'd5, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b0);
    send(2'd0, 64'h5555_5555_5555_5555, 4'd6, 64'h5555_5555_5555_5555, 1'b0, 1'b0);
    chk("inflight_out_valid", 64'(o_vld[0]), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(o_vld[0]), 64'd0);
    chk("async_rst_out_data", o_data[0], 64'd0);
    chk("async_rst_busy", 64'(bsy[0]), 64'd0);
    for (int d = 0; d < ND; d++) sb[d].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(2'd1, 64'h0000_0000_0000_0001, 4'd3, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    drain();

    // Latency on the STAGES=1 and STAGES=4 instances
    lat_en = 1'b1;
    send(2'd1, 64'h0000_0000_0000_0001, 4'd3, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    drain();
    send(2'd3, 64'h0000_0000_0000_01F0, 4'd9, 64'h0000_0000_0000_800F, 1'b1, 1'b0);
    drain();
    lat_en = 1'b0;

    chk("scoreboard_empty", 64'(sb[0].size() + sb[1].size() + sb[2].size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, expected the run to finish", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
